sprite_motion: RTL and testbench

//   Frame-synchronous sprite position engine; feeds SpriteX/SpriteY to the LCD pixel stage.

---
 rtl/sprite_motion.sv | 125 ++++++++++++
 tb/tb_sprite_motion.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_motion.sv
// Frame-synchronous sprite position engine: bounces (or, with SPRITE_MOTION_WRAP_EN
// defined, wraps) a sprite inside the active area and publishes each new position atomically.
module sprite_motion #(
  parameter int H_VALID   = 480,
  parameter int V_VALID   = 272,
  parameter int SPRITE_W  = 16,
  parameter int SPRITE_H  = 16,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1,
  parameter int INIT_X    = 0,
  parameter int INIT_Y    = 0
) (
  input  logic       PixelClk,
  input  logic       RST,
  input  logic       FrameStart,
  input  logic       Enable,
  output logic [9:0] SpriteX,
  output logic [8:0] SpriteY,
  output logic       DirX,
  output logic       DirY,
  output logic       PosValid
);

  localparam logic [10:0] MAX_X   = 11'(H_VALID - SPRITE_W);
  localparam logic [10:0] MAX_Y   = 11'(V_VALID - SPRITE_H);
  localparam logic [10:0] STEP_V  = 11'(STEP);
  localparam logic [10:0] INIT_XV = 11'(INIT_X);
  localparam logic [10:0] INIT_YV = 11'(INIT_Y);

  localparam int               CNT_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    CALC_X,
    CALC_Y,
    COMMIT
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] frame_cnt;
  logic [10:0]      work_x;
  logic [10:0]      work_y;
  logic             work_dir_x;
  logic             work_dir_y;

  // Returns {new_dir, new_pos} for one axis; a start beyond max_pos counts as a forward edge hit.
  function automatic logic [11:0] advance(input logic [10:0] pos, input logic dir,
                                          input logic [10:0] max_pos);
    logic [10:0] sum;
    logic [11:0] res;
    sum = pos + STEP_V;
`ifdef SPRITE_MOTION_WRAP_EN
    if (sum > max_pos) res = {1'b0, sum - (max_pos + 11'd1)};
    else               res = {1'b0, sum};
    res[11] = res[11] & dir;
`else
    if (!dir) begin
      if (sum >= max_pos) res = {1'b1, max_pos};
      else                res = {1'b0, sum};
    end else begin
      if (pos <= STEP_V)  res = {1'b0, 11'd0};
      else                res = {1'b1, pos - STEP_V};
    end
`endif
    return res;
  endfunction

  // NOTE: every register, outputs included, lives in this one clocked block and is
  // written only with <=, so all reads see the previous-cycle value regardless of order.
  always_ff @(posedge PixelClk) begin
    if (RST) begin
      state      <= IDLE;
      frame_cnt  <= '0;
      work_x     <= INIT_XV;
      work_y     <= INIT_YV;
      work_dir_x <= 1'b0;
      work_dir_y <= 1'b0;
      SpriteX    <= INIT_XV[9:0];
      SpriteY    <= INIT_YV[8:0];
      DirX       <= 1'b0;
      DirY       <= 1'b0;
      PosValid   <= 1'b0;
    end else begin
      PosValid <= 1'b0;
      case (state)
        IDLE: begin
          if (Enable) state <= WAIT;
        end
        WAIT: begin
          if (!Enable) begin
            state <= IDLE;
          end else if (FrameStart) begin
            if (frame_cnt == CNT_LAST) begin
              frame_cnt <= '0;
              state     <= CALC_X;
            end else begin
              frame_cnt <= frame_cnt + CNT_W'(1);
            end
          end
        end
        CALC_X: begin
          {work_dir_x, work_x} <= advance(work_x, work_dir_x, MAX_X);
          state                <= CALC_Y;
        end
        CALC_Y: begin
          {work_dir_y, work_y} <= advance(work_y, work_dir_y, MAX_Y);
          state                <= COMMIT;
        end
        COMMIT: begin
          // Both axes land in the same edge so the pixel stage never sees a mixed pair.
          SpriteX  <= work_x[9:0];
          SpriteY  <= work_y[8:0];
          DirX     <= work_dir_x;
          DirY     <= work_dir_y;
          PosValid <= 1'b1;
          state    <= WAIT;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sprite_motion.sv
// Scoreboard bench for sprite_motion: four differently configured instances share the
// stimulus; predicted commits are queued when FrameStart is accepted and popped on PosValid.
module tb_sprite_motion;

  localparam int N = 4;
  localparam int IX[N] = '{5, 10, 463, 464};
  localparam int IY[N] = '{7, 20, 1, 300};
  localparam int ST[N] = '{1, 1, 2, 1};
  localparam int DV[N] = '{1, 3, 1, 1};
  localparam int MX[N] = '{464, 464, 464, 464};
  localparam int MY[N] = '{256, 256, 5, 256};

  logic       PixelClk = 1'b0;
  logic       RST = 1'b1;
  logic       FrameStart = 1'b0;
  logic       Enable = 1'b0;
  logic [9:0] sx[N];
  logic [8:0] sy[N];
  logic       dx[N];
  logic       dy[N];
  logic       pv[N];

  sprite_motion #(.INIT_X(5), .INIT_Y(7)) u0 (
    .PixelClk(PixelClk), .RST(RST), .FrameStart(FrameStart), .Enable(Enable),
    .SpriteX(sx[0]), .SpriteY(sy[0]), .DirX(dx[0]), .DirY(dy[0]), .PosValid(pv[0]));
  sprite_motion #(.FRAME_DIV(3), .INIT_X(10), .INIT_Y(20)) u1 (
    .PixelClk(PixelClk), .RST(RST), .FrameStart(FrameStart), .Enable(Enable),
    .SpriteX(sx[1]), .SpriteY(sy[1]), .DirX(dx[1]), .DirY(dy[1]), .PosValid(pv[1]));
  sprite_motion #(.V_VALID(21), .STEP(2), .INIT_X(463), .INIT_Y(1)) u2 (
    .PixelClk(PixelClk), .RST(RST), .FrameStart(FrameStart), .Enable(Enable),
    .SpriteX(sx[2]), .SpriteY(sy[2]), .DirX(dx[2]), .DirY(dy[2]), .PosValid(pv[2]));
  sprite_motion #(.INIT_X(464), .INIT_Y(300)) u3 (
    .PixelClk(PixelClk), .RST(RST), .FrameStart(FrameStart), .Enable(Enable),
    .SpriteX(sx[3]), .SpriteY(sy[3]), .DirX(dx[3]), .DirY(dy[3]), .PosValid(pv[3]));

  always #5 PixelClk = ~PixelClk;

  typedef struct {
    int x;
    int y;
    int dx;
    int dy;
    int cyc;
  } exp_t;

  exp_t sb[N][$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   pv_cnt[N];
  int   m_st[N];
  int   m_cnt[N];
  int   m_busy[N];
  int   cx[N], cy[N], cdx[N], cdy[N];
  int   px[N], py[N], pdx[N], pdy[N];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void next_pos(input int p, input int d, input int mx, input int st,
                                   output int np, output int nd);
`ifdef SPRITE_MOTION_WRAP_EN
    nd = 0;
    np = (p + st > mx) ? p + st - (mx + 1) : p + st;
`else
    if (d == 0) begin
      if (p + st >= mx) begin np = mx; nd = 1; end
      else              begin np = p + st; nd = 0; end
    end else begin
      if (p <= st) begin np = 0; nd = 0; end
      else         begin np = p - st; nd = 1; end
    end
`endif
  endfunction

  // Transaction-level reference: idle/waiting/busy per instance, predictions pushed on acceptance.
  always @(posedge PixelClk) begin
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (RST) begin
        m_st[i] = 0; m_cnt[i] = 0; m_busy[i] = 0;
        cx[i] = IX[i]; cy[i] = IY[i]; cdx[i] = 0; cdy[i] = 0;
        sb[i].delete();
      end else if (m_busy[i] > 0) begin
        m_busy[i]--;
        if (m_busy[i] == 0) begin
          cx[i] = px[i]; cy[i] = py[i]; cdx[i] = pdx[i]; cdy[i] = pdy[i];
          m_st[i] = 1;
        end
      end else if (m_st[i] == 0) begin
        if (Enable) m_st[i] = 1;
      end else if (!Enable) begin
        m_st[i] = 0;
      end else if (FrameStart) begin
        if (m_cnt[i] == DV[i] - 1) begin
          exp_t e;
          m_cnt[i]  = 0;
          m_busy[i] = 3;
          next_pos(cx[i], cdx[i], MX[i], ST[i], px[i], pdx[i]);
          next_pos(cy[i], cdy[i], MY[i], ST[i], py[i], pdy[i]);
          e.x = px[i]; e.y = py[i]; e.dx = pdx[i]; e.dy = pdy[i]; e.cyc = cyc + 3;
          sb[i].push_back(e);
        end else begin
          m_cnt[i]++;
        end
      end
    end
  end

  always @(negedge PixelClk) begin
    for (int i = 0; i < N; i++) begin
      if (sb[i].size() > 0 && sb[i][0].cyc < cyc) begin
        check($sformatf("u%0d_missed_pv", i), 0, 1);
        void'(sb[i].pop_front());
      end
      if (pv[i] === 1'b1) begin
        pv_cnt[i]++;
        if (sb[i].size() == 0) begin
          check($sformatf("u%0d_unexpected_pv", i), 1, 0);
        end else begin
          exp_t e;
          e = sb[i].pop_front();
          check($sformatf("u%0d_latency", i), cyc, e.cyc);
          check($sformatf("u%0d_x", i), sx[i], e.x);
          check($sformatf("u%0d_y", i), sy[i], e.y);
          check($sformatf("u%0d_dx", i), dx[i], e.dx);
          check($sformatf("u%0d_dy", i), dy[i], e.dy);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge PixelClk);
  endtask

  task automatic pulse();
    @(negedge PixelClk) FrameStart = 1'b1;
    @(negedge PixelClk) FrameStart = 1'b0;
  endtask

  task automatic check_init(input string tag);
    for (int i = 0; i < N; i++) begin
      check($sformatf("%s_u%0d_x", tag, i), sx[i], IX[i]);
      check($sformatf("%s_u%0d_y", tag, i), sy[i], IY[i]);
      check($sformatf("%s_u%0d_dx", tag, i), dx[i], 0);
      check($sformatf("%s_u%0d_dy", tag, i), dy[i], 0);
      check($sformatf("%s_u%0d_pv", tag, i), pv[i], 0);
    end
  endtask

  initial begin
    int base;
    for (int i = 0; i < N; i++) pv_cnt[i] = 0;
    RST = 1'b1; Enable = 1'b0; FrameStart = 1'b0;
    idle(2);
    check_init("reset");
    RST = 1'b0;

    // FrameStart while idle must not move anything.
    pulse();
    idle(5);
    check("idle_hold_x", sx[0], 5);

    Enable = 1'b1;
    idle(2);
    base = pv_cnt[1];
    pulse();
    idle(4);
    check("first_x", sx[0], 6);
    check("first_y", sy[0], 8);
`ifdef SPRITE_MOTION_WRAP_EN
    check("wrap_x", sx[3], 0);
    check("wrap_dx", dx[3], 0);
`else
    check("edge_x", sx[2], 464);
    check("edge_dx", dx[2], 1);
    check("clamp_y", sy[3], 256);
    check("clamp_dy", dy[3], 1);
`endif
    pulse();
    idle(4);
`ifndef SPRITE_MOTION_WRAP_EN
    check("bounce_x", sx[2], 462);
`endif
    repeat (4) begin
      pulse();
      idle(4);
    end
    check("div3_pulses", pv_cnt[1] - base, 2);
    check("div3_x", sx[1], 12);
    check("div3_y", sy[1], 22);

    // FrameStart held high: busy-state pulses dropped, the one after COMMIT accepted.
    @(negedge PixelClk) FrameStart = 1'b1;
    idle(5);
    FrameStart = 1'b0;
    idle(5);

    // Enable dropped mid-update: the update still completes.
    pulse();
    Enable = 1'b0;
    idle(5);
    pulse();
    idle(5);
    Enable = 1'b1;
    idle(2);

    repeat (40) begin
      Enable = ($urandom_range(0, 7) != 0);
      pulse();
      idle($urandom_range(1, 6));
    end
    Enable = 1'b1;
    idle(6);

    // Reset two edges after acceptance discards the in-flight update.
    pulse();
    @(negedge PixelClk) RST = 1'b1;
    @(negedge PixelClk) RST = 1'b0;
    check_init("abort");
    idle(6);
    check_init("abort_hold");

    for (int i = 0; i < N; i++) check($sformatf("u%0d_sb_empty", i), sb[i].size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
